div_issue_ctrl: RTL and testbench

- Round-robin controller that shares one iterative 32-bit divider (div_req/div_signed/x/y in; s/r/complete out) between two requesters.
- Latches the operands, holds the divider's start level for the whole operation, and captures the quotient or remainder selected by the opcode.
- Presents the result on a valid/ready port with a tag.
- Supports pipeline flush and a watchdog timeout.

---
 rtl/div_issue_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Round-robin issue controller sharing one iterative divider between two requesters.
// Optional macro DIV_CTRL_ZERO_BYPASS_EN: divide-by-zero results produced without the divider.
module div_issue_ctrl #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req0_y,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_x,
    input  logic [31:0]      req1_y,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_src,
    output logic             res_err,
    output logic             div_req,
    output logic             div_signed,
    output logic [31:0]      div_x,
    output logic [31:0]      div_y,
    input  logic [31:0]      div_s,
    input  logic [31:0]      div_r,
    input  logic             div_complete
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       x_q, x_d, y_q, y_d;
    logic              rem_sel_q, rem_sel_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              src_q, src_d;
    logic              signed_q, signed_d;
    logic [31:0]       res_data_q, res_data_d;
    logic              res_err_q, res_err_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              grant_src;
    logic              accept;
    logic [1:0]        sel_op;
    logic [31:0]       sel_x, sel_y;
    logic [TAG_W-1:0]  sel_tag;

    // With both valid the requester that did not win last time is granted.
    always_comb begin
        grant_src = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        accept    = resetn & (state_q == IDLE) & ~flush & (req0_valid | req1_valid);
        sel_op    = grant_src ? req1_op  : req0_op;
        sel_x     = grant_src ? req1_x   : req0_x;
        sel_y     = grant_src ? req1_y   : req0_y;
        sel_tag   = grant_src ? req1_tag : req0_tag;
    end

    assign req0_ready = accept & ~grant_src;
    assign req1_ready = accept &  grant_src;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        x_d          = x_q;
        y_d          = y_q;
        rem_sel_d    = rem_sel_q;
        tag_d        = tag_q;
        src_d        = src_q;
        signed_d     = signed_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        wd_d         = wd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d          = sel_x;
                    y_d          = sel_y;
                    rem_sel_d    = sel_op[0];
                    tag_d        = sel_tag;
                    src_d        = grant_src;
                    last_grant_d = grant_src;
                    signed_d     = ~sel_op[1];
                    wd_d         = '0;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
                    if (sel_y == 32'd0) begin
                        state_d    = HOLD;
                        res_data_d = sel_op[0] ? sel_x : 32'hFFFF_FFFF;
                        res_err_d  = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    wd_d    = '0;
                end else if (div_complete) begin
                    state_d = DRAIN;
                    wd_d    = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d    = HOLD;
                    res_data_d = 32'hFFFF_FFFF;
                    res_err_d  = 1'b1;
                    wd_d       = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            // Divider outputs are sampled one cycle after its done pulse.
            DRAIN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    res_data_d = rem_sel_q ? div_r : div_s;
                    res_err_d  = 1'b0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (flush || res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            rem_sel_q    <= 1'b0;
            tag_q        <= '0;
            src_q        <= 1'b0;
            signed_q     <= 1'b0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rem_sel_q    <= rem_sel_d;
            tag_q        <= tag_d;
            src_q        <= src_d;
            signed_q     <= signed_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            wd_q         <= wd_d;
        end
    end

    assign div_req    = (state_q == RUN) || (state_q == DRAIN);
    assign div_signed = signed_q;
    assign div_x      = x_q;
    assign div_y      = y_q;
    assign res_valid  = (state_q == HOLD);
    assign res_data   = res_data_q;
    assign res_tag    = tag_q;
    assign res_src    = src_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: stub divider, timestamp-based reference model, directed vectors.
// Honours DIV_CTRL_ZERO_BYPASS_EN when the design is built with it.
module tb_div_issue_ctrl;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn = 1'b0;
    logic             req0_valid = 0, req1_valid = 0, flush = 0, res_ready = 1;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op = '0, req1_op = '0;
    logic [31:0]      req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             res_valid, res_src, res_err;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             div_req, div_signed, div_complete;
    logic [31:0]      div_x, div_y, div_s, div_r;

    div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y), .req1_tag(req1_tag),
        .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_src(res_src), .res_err(res_err),
        .div_req(div_req), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
    );

    int n_vec = 0;
    int n_err = 0;
    int n     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    // Truncating division; divide-by-zero yields all ones / dividend.
    function automatic logic [63:0] divfn(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [31:0] q, r;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (sgn) begin
            q = 32'($signed(x) / $signed(y));
            r = 32'($signed(x) % $signed(y));
        end else begin
            q = x / y;
            r = x % y;
        end
        return {q, r};
    endfunction

    // Stub divider: done pulse a programmable number of cycles after start.
    int   scnt = 0;
    int   stub_lat = 3;
    bit   stub_en = 1;
    logic stub_cmp = 1'b0;
    logic stray = 1'b0;
    logic [63:0] qr;
    assign qr = divfn(div_x, div_y, div_signed);
    assign div_s = qr[63:32];
    assign div_r = qr[31:0];
    assign div_complete = stub_cmp | stray;
    always @(posedge clk) begin
        if (!div_req) scnt <= 0;
        else scnt <= scnt + 1;
        stub_cmp <= stub_en && div_req && (scnt == stub_lat - 1);
    end

    // Reference model: tracks the in-flight operation by timestamps.
    bit               m_busy = 0;
    bit               m_last = 1;
    int               m_tacc = 0;
    int               m_rat = -1;
    logic [31:0]      m_x, m_y, m_data;
    logic [1:0]       m_op;
    logic [TAG_W-1:0] m_tag;
    logic             m_src, m_err;

    always @(negedge clk) begin
        bit e_gsrc, e_acc, running, e_dreq, e_rv;
        logic [63:0] eqr;
        n++;
        if (!resetn) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_div_req", div_req, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_res_meta", {res_tag, res_src, res_err, div_signed}, 0);
            chk("rst_div_x", div_x, 0);
            chk("rst_div_y", div_y, 0);
            m_busy = 0;
            m_last = 1;
            m_rat  = -1;
        end else begin
            e_gsrc  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_acc   = !m_busy && !flush && (req0_valid || req1_valid);
            running = m_busy && (m_rat < 0);
            e_dreq  = m_busy && ((m_rat < 0) || (n < m_rat));
            e_rv    = m_busy && (m_rat >= 0) && (n >= m_rat);
            chk("req0_ready", req0_ready, e_acc && !e_gsrc);
            chk("req1_ready", req1_ready, e_acc && e_gsrc);
            chk("div_req", div_req, e_dreq);
            if (e_dreq) begin
                chk("div_x", div_x, m_x);
                chk("div_y", div_y, m_y);
                chk("div_signed", div_signed, !m_op[1]);
            end
            chk("res_valid", res_valid, e_rv);
            if (e_rv) begin
                chk("res_data", res_data, m_data);
                chk("res_meta", {res_tag, res_src, res_err}, {m_tag, m_src, m_err});
            end
            if (m_busy) begin
                if (flush) begin
                    m_busy = 0;
                end else if (running && div_complete) begin
                    eqr    = divfn(m_x, m_y, !m_op[1]);
                    m_data = m_op[0] ? eqr[31:0] : eqr[63:32];
                    m_err  = 0;
                    m_rat  = n + 2;
                end else if (running && (n - m_tacc == TIMEOUT)) begin
                    m_data = 32'hFFFF_FFFF;
                    m_err  = 1;
                    m_rat  = n + 1;
                end else if (e_rv && res_ready) begin
                    $display("result src=%0d tag=%h data=%h err=%0d cycle=%0d",
                             res_src, res_tag, res_data, res_err, n);
                    m_busy = 0;
                end
            end else if (e_acc) begin
                m_src  = e_gsrc;
                m_op   = e_gsrc ? req1_op  : req0_op;
                m_x    = e_gsrc ? req1_x   : req0_x;
                m_y    = e_gsrc ? req1_y   : req0_y;
                m_tag  = e_gsrc ? req1_tag : req0_tag;
                m_last = e_gsrc;
                m_tacc = n;
                m_rat  = -1;
                m_busy = 1;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
                if (m_y == 32'd0) begin
                    m_data = m_op[0] ? m_x : 32'hFFFF_FFFF;
                    m_err  = 0;
                    m_rat  = n + 1;
                end
`endif
            end
        end
    end

    task automatic issue(input bit s, input logic [1:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [TAG_W-1:0] tag);
        bit got;
        got = 0;
        @(posedge clk); #1;
        if (s) begin req1_op = op; req1_x = x; req1_y = y; req1_tag = tag; req1_valid = 1; end
        else   begin req0_op = op; req0_x = x; req0_y = y; req0_tag = tag; req0_valid = 1; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s ? req1_ready : req0_ready) begin got = 1; break; end
        end
        chk("accept_wait", got, 1);
        @(posedge clk); #1;
        if (s) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_result(output logic [31:0] d, output logic [TAG_W-1:0] t,
                               output logic s, output logic e, output int lat);
        bit got;
        got = 0; lat = -1; d = '0; t = '0; s = 0; e = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid && res_ready && !flush) begin
                got = 1; lat = i; d = res_data; t = res_tag; s = res_src; e = res_err;
                break;
            end
        end
        chk("result_wait", got, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 300us");
        $fatal(1);
    end

    initial begin
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        logic             s, e;
        int               lat, cnt;
        logic [3:0]       gseq;

        repeat (3) @(negedge clk);
        chk("rst_lit_div_req", div_req, 0);
        @(posedge clk); #1 resetn = 1;

        // div.w -7 / 2 from requester 0
        issue(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 4'h5);
        wait_result(d, t, s, e, lat);
        chk("t1_data", d, 32'hFFFF_FFFD);
        chk("t1_src_tag_err", {s, t, e}, {1'b0, 4'h5, 1'b0});
        chk("t1_latency", lat, 5);

        // mod.wu 100 % 7 from requester 1
        issue(1, 2'b11, 32'd100, 32'd7, 4'h9);
        wait_result(d, t, s, e, lat);
        chk("t2_data", d, 32'd2);
        chk("t2_src_tag", {s, t}, {1'b1, 4'h9});

        // both requesters continuously valid: grants alternate
        @(posedge clk); #1;
        req0_op = 2'b01; req0_x = 32'd17; req0_y = 32'd5; req0_tag = 4'h1;
        req1_op = 2'b10; req1_x = 32'd90; req1_y = 32'd9; req1_tag = 4'h2;
        req0_valid = 1; req1_valid = 1;
        cnt = 0; gseq = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gseq[cnt] = req1_ready;
                cnt++;
                if (cnt == 4) break;
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        chk("t3_count", cnt, 4);
        chk("t3_grants", gseq, 4'b1010);
        repeat (15) @(posedge clk);
        #1;

        // consumer stalls for 5 cycles in HOLD while requester 1 waits
        res_ready = 0;
        issue(0, 2'b10, 32'd1000, 32'd10, 4'h3);
        req1_op = 2'b00; req1_x = 32'd64; req1_y = 32'd8; req1_tag = 4'h4; req1_valid = 1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid) begin cnt = 1; break; end
        end
        chk("t4_valid_wait", cnt, 1);
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_data", res_data, 32'd100);
            chk("t4_hold_noready", req1_ready, 0);
        end
        @(posedge clk); #1 res_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_accept_next", req1_ready, 1);
        @(posedge clk); #1 req1_valid = 0;
        wait_result(d, t, s, e, lat);
        chk("t4_next_data", d, 32'd8);

        // flush ten cycles into RUN
        stub_lat = 30;
        issue(0, 2'b00, 32'd50, 32'd5, 4'h6);
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("t5_flush_div_req", div_req, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_flush_no_valid", res_valid, 0);
        end
        stub_lat = 3;
        issue(1, 2'b00, 32'd77, 32'd7, 4'h7);
        wait_result(d, t, s, e, lat);
        chk("t5_after_flush", d, 32'd11);

        // watchdog: divider never completes
        stub_en = 0;
        issue(1, 2'b00, 32'd123, 32'd4, 4'h8);
        wait_result(d, t, s, e, lat);
        chk("t6_data", d, 32'hFFFF_FFFF);
        chk("t6_err", e, 1);
        chk("t6_latency", lat, TIMEOUT);
        stub_en = 1;

        // flush drops a pending result in HOLD
        res_ready = 0;
        issue(0, 2'b01, 32'd33, 32'd4, 4'hA);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("t7_hold_flush", res_valid, 0);
        res_ready = 1;

        // flush in IDLE blocks acceptance for that cycle
        @(posedge clk); #1;
        flush = 1; req0_op = 2'b00; req0_x = 32'd9; req0_y = 32'd3; req0_tag = 4'hB; req0_valid = 1;
        @(negedge clk);
        chk("t8_flush_blocks", req0_ready, 0);
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("t8_accept", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 0;
        wait_result(d, t, s, e, lat);
        chk("t8_data", d, 32'd3);

        // stray done pulse while idle is ignored
        @(posedge clk); #1 stray = 1;
        @(posedge clk); #1 stray = 0;
        @(negedge clk);
        chk("t9_stray", {div_req, res_valid}, 2'b00);

        // reset mid-operation, then req0 wins the first tie again
        stub_lat = 10;
        issue(1, 2'b00, 32'd20, 32'd4, 4'hC);
        @(posedge clk); #1 resetn = 0;
        @(negedge clk);
        chk("t10_rst_div_req", div_req, 0);
        @(posedge clk); #1 resetn = 1;
        stub_lat = 3;
        req0_op = 2'b00; req0_x = 32'd21; req0_y = 32'd7; req0_tag = 4'hD;
        req1_op = 2'b00; req1_x = 32'd8;  req1_y = 32'd2; req1_tag = 4'hE;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("t10_tie_after_rst", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        wait_result(d, t, s, e, lat);
        chk("t10_data", d, 32'd3);

        // divide by zero
        issue(0, 2'b00, 32'd5, 32'd0, 4'h2);
        wait_result(d, t, s, e, lat);
        chk("t11_div0_q", d, 32'hFFFF_FFFF);
        chk("t11_div0_err", e, 0);
`ifdef DIV_CTRL_ZERO_BYPASS_EN
        chk("t11_div0_latency", lat, 0);
`else
        chk("t11_div0_latency", lat, 5);
`endif
        issue(1, 2'b11, 32'd55, 32'd0, 4'h3);
        wait_result(d, t, s, e, lat);
        chk("t11_mod0_r", d, 32'd55);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
